multibyte_add_seq: RTL and testbench

//   Sequencer that adds or subtracts two NBYTES-wide operands using one 8-bit

---
 rtl/multibyte_add_seq.sv | 137 +++++++++++++
 tb/tb_multibyte_add_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multibyte_add_seq.sv
// Byte-serial wide add/subtract sequencer around one shared 8-bit full adder.
// Latency: done pulses NBYTES edges after the accepted start edge; one op per NBYTES+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.

// 8-bit ripple adder slice shared by the sequencer.
module fulladder8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       cin_i,
   output logic [7:0] s_o,
   output logic       cout_o
);
   assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
endmodule

module multibyte_add_seq #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                op_sub,
   input  logic [8*NBYTES-1:0] a,
   input  logic [8*NBYTES-1:0] b,
   input  logic                cin,
   output logic                busy,
   output logic                done,
   output logic [8*NBYTES-1:0] sum,
   output logic                cout,
   output logic                ovf
);
   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   // Holds the effective B operand: already inverted for subtract.
   logic [W-1:0]    b_q, b_d;
   logic            carry_q, carry_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;
   logic            done_q, done_d;

   logic [7:0]      fa_a, fa_b, fa_s;
   logic            fa_cout;

   assign fa_a = a_q[8*idx_q +: 8];
   assign fa_b = b_q[8*idx_q +: 8];

   fulladder8 u_fa (
      .a_i    (fa_a),
      .b_i    (fa_b),
      .cin_i  (carry_q),
      .s_o    (fa_s),
      .cout_o (fa_cout)
   );

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

   // Next-state logic: capture on start, one byte per RUN cycle, single-cycle DONE.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = op_sub ? ~b : b;
               // Subtract is a + ~b + 1, so the caller's cin is not used.
               carry_d = op_sub ? 1'b1 : cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[8*idx_q +: 8] = fa_s;
            carry_d             = fa_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = fa_cout;
               // Same-sign operands producing a different-sign result.
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (fa_s[7] != a_q[W-1]);
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset overriding everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq with NBYTES=4.
// Directed corner cases, ignored starts, mid-run reset, held start, random ops.
// Results checked against a signed/unsigned integer model of the arithmetic.
module tb_multibyte_add_seq;
   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          op_sub;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;

   int n_checks = 0;
   int n_fail   = 0;

   multibyte_add_seq #(.NBYTES(NB)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_sub (op_sub),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .busy   (busy),
      .done   (done),
      .sum    (sum),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   // Integer model: unsigned result for sum/cout, signed range test for ovf.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mop, input logic mcin,
                                 output logic [W-1:0] ms, output logic mc, output logic mo);
      longint unsigned ua, ub, ur;
      longint sa, sb, sr;
      ua = 64'(ma);
      ub = 64'(mb);
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      if (mop) begin
         ur = ua - ub;
         mc = (ua >= ub);
         sr = sa - sb;
      end else begin
         ur = ua + ub + 64'(mcin);
         mc = (ur > 64'h0000_0000_FFFF_FFFF);
         sr = sa + sb + longint'(mcin);
      end
      ms = ur[W-1:0];
      mo = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
   endfunction

   // Drives one operation and reports timing observations; callers do the checks.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic top, input logic tcin,
                        output int lat, output logic busy0,
                        output logic done_after, output logic busy_after);
      a = ta; b = tb_v; op_sub = top; cin = tcin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom; cin = $urandom_range(0, 1);
      busy0 = busy;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      @(posedge clk); #1;
      done_after = done;
      busy_after = busy;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0", sum); end
      n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [5] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h7FFF_FFFF};
      logic [W-1:0] tv [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h0000_0000};
      logic         to [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [W-1:0] es [5] = '{32'h0000_0100, 32'h0000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000};
      logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic         eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int lat;
      logic b0, da, ba;
      for (int i = 0; i < 5; i++) begin
         do_op(ta[i], tv[i], to[i], tc[i], lat, b0, da, ba);
         n_checks++; if (lat != NB) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NB); end
         n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy_after_start got=%b exp=1", i, b0); end
         n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width got=%b exp=0", i, da); end
         n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_end got=%b exp=0", i, ba); end
         n_checks++; if (sum !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum got=%h exp=%h", i, sum, es[i]); end
         n_checks++; if (cout !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout got=%b exp=%b", i, cout, ec[i]); end
         n_checks++; if (ovf !== eo[i]) begin n_fail++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, eo[i]); end
      end
   endtask

   task automatic test_ignore_start;
      a = 32'h7FFF_FFFF; b = '0; cin = 1'b1; op_sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; a = 32'h1234_5678; b = 32'h0BAD_F00D; op_sub = 1'b1; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done got=%b exp=1", done); end
      n_checks++; if (sum !== 32'h8000_0000) begin n_fail++; $display("FAIL ign_sum got=%h exp=80000000", sum); end
      n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ign_ovf got=%b exp=1", ovf); end
      n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL ign_cout got=%b exp=0", cout); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle_busy got=%b exp=0", busy); end
      n_checks++; if (sum !== 32'h8000_0000) begin n_fail++; $display("FAIL ign_sum_hold got=%h exp=80000000", sum); end
   endtask

   task automatic test_mid_reset;
      int lat;
      logic b0, da, ba;
      logic [W-1:0] es;
      logic ec, eo;
      a = 32'h1122_3344; b = 32'h0101_0101; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got=%b exp=0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mrst_done got=%b exp=0", done); end
      n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL mrst_sum got=%h exp=0", sum); end
      n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL mrst_cout got=%b exp=0", cout); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mrst_ovf got=%b exp=0", ovf); end
      model(32'hA5A5_5A5A, 32'h5A5A_A5A5, 1'b0, 1'b1, es, ec, eo);
      do_op(32'hA5A5_5A5A, 32'h5A5A_A5A5, 1'b0, 1'b1, lat, b0, da, ba);
      n_checks++; if (lat != NB) begin n_fail++; $display("FAIL mrst_after_latency got=%0d exp=%0d", lat, NB); end
      n_checks++; if (sum !== es) begin n_fail++; $display("FAIL mrst_after_sum got=%h exp=%h", sum, es); end
      n_checks++; if (cout !== ec) begin n_fail++; $display("FAIL mrst_after_cout got=%b exp=%b", cout, ec); end
   endtask

   task automatic test_back_to_back;
      logic dlog [30];
      logic blog [30];
      logic [W-1:0] slog [30];
      logic [W-1:0] ta, tv, es;
      logic top, tc, ec, eo;
      int first;
      ta = $urandom; tv = $urandom; top = $urandom_range(0, 1); tc = $urandom_range(0, 1);
      model(ta, tv, top, tc, es, ec, eo);
      a = ta; b = tv; op_sub = top; cin = tc; start = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         dlog[c] = done; blog[c] = busy; slog[c] = sum;
      end
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      first = -1;
      for (int c = 0; c < 30; c++) if (dlog[c] === 1'b1 && first < 0) first = c;
      n_checks++; if (first != NB) begin n_fail++; $display("FAIL b2b_first_done got=%0d exp=%0d", first, NB); end
      if (first >= 0) begin
         for (int c = first; c < 30; c++) begin
            n_checks++;
            if (dlog[c] !== (((c - first) % 6) == 0)) begin
               n_fail++; $display("FAIL b2b_done_c%0d got=%b exp=%b", c, dlog[c], ((c - first) % 6) == 0);
            end
            n_checks++;
            if (blog[c] !== (((c - first) % 6) != 1)) begin
               n_fail++; $display("FAIL b2b_busy_c%0d got=%b exp=%b", c, blog[c], ((c - first) % 6) != 1);
            end
            if (dlog[c] === 1'b1) begin
               n_checks++;
               if (slog[c] !== es) begin n_fail++; $display("FAIL b2b_sum_c%0d got=%h exp=%h", c, slog[c], es); end
            end
         end
      end
   endtask

   task automatic test_random;
      logic [W-1:0] ta, tv, es;
      logic top, tc, ec, eo, b0, da, ba;
      int lat;
      for (int i = 0; i < 40; i++) begin
         ta = $urandom; tv = $urandom;
         if (i % 5 == 0) tv = ta;
         if (i % 7 == 1) ta = {1'b1, 31'($urandom)} & 32'h8000_00FF;
         top = $urandom_range(0, 1); tc = $urandom_range(0, 1);
         model(ta, tv, top, tc, es, ec, eo);
         do_op(ta, tv, top, tc, lat, b0, da, ba);
         n_checks++; if (lat != NB) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, NB); end
         n_checks++; if (sum !== es) begin n_fail++; $display("FAIL rnd%0d_sum a=%h b=%h sub=%b got=%h exp=%h", i, ta, tv, top, sum, es); end
         n_checks++; if (cout !== ec) begin n_fail++; $display("FAIL rnd%0d_cout got=%b exp=%b", i, cout, ec); end
         n_checks++; if (ovf !== eo) begin n_fail++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, ovf, eo); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
